// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem initiator: bus widths and the transfer FSM state encoding.
package iomem_pkg;

    localparam int unsigned IOMEM_AW = 32;
    localparam int unsigned IOMEM_DW = 32;
    localparam int unsigned IOMEM_SW = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUS,
        ST_RESP
    } iomem_state_e;

endpackage

// File: rtl/iomem_initiator_if.sv
// Command/response interface and iomem bus interface.
// Modports are written from the point of view of the initiator: slave takes commands, master drives the bus.
interface iomem_cmd_if;
    import iomem_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [IOMEM_AW-1:0] cmd_addr;
    logic [IOMEM_DW-1:0] cmd_wdata;
    logic [IOMEM_SW-1:0] cmd_wstrb;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IOMEM_DW-1:0] rsp_rdata;
    logic                rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

interface iomem_bus_if;
    import iomem_pkg::*;

    logic                iomem_valid;
    logic                iomem_ready;
    logic [IOMEM_AW-1:0] iomem_addr;
    logic [IOMEM_DW-1:0] iomem_wdata;
    logic [IOMEM_SW-1:0] iomem_wstrb;
    logic [IOMEM_DW-1:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_addr, iomem_wdata, iomem_wstrb,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_timeout_ctr.sv
// Bus-phase watchdog: counts cycles while enabled, asserts expired on the
// cycle in which the count would reach LIMIT.
module iomem_timeout_ctr #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires during the LIMIT-th waiting cycle so valid is high for exactly LIMIT cycles.
    assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus initiator: accepts one command, runs it on the
// bus with a timeout, and holds the response until it is consumed.
module iomem_initiator
    import iomem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    iomem_cmd_if.slave      cmd,
    iomem_bus_if.master     bus,
    output logic            busy
);

    iomem_state_e        state_q, state_d;
    logic [IOMEM_AW-1:0] addr_q, addr_d;
    logic [IOMEM_DW-1:0] wdata_q, wdata_d;
    logic [IOMEM_SW-1:0] wstrb_q, wstrb_d;
    logic [IOMEM_DW-1:0] rdata_q, rdata_d;
    logic                err_q, err_d;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expired;

    assign tmo_clear  = (state_q != ST_BUS);
    assign tmo_enable = (state_q == ST_BUS) && !bus.iomem_ready;

    iomem_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    addr_d  = cmd.cmd_addr;
                    wdata_d = cmd.cmd_wdata;
                    wstrb_d = cmd.cmd_wstrb;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // Completion wins over a timeout landing in the same cycle.
                if (bus.iomem_ready) begin
                    rdata_d = (wstrb_q == '0) ? bus.iomem_rdata : '0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cmd.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cmd.cmd_ready   = (state_q == ST_IDLE) && !rst;
    assign cmd.rsp_valid   = (state_q == ST_RESP);
    assign cmd.rsp_rdata   = rdata_q;
    assign cmd.rsp_err     = err_q;
    assign bus.iomem_valid = (state_q == ST_BUS);
    assign bus.iomem_addr  = addr_q;
    assign bus.iomem_wdata = wdata_q;
    assign bus.iomem_wstrb = wstrb_q;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_iomem_initiator.sv
// Scenario bench for iomem_initiator (TIMEOUT_CYCLES=8): expected responses are
// queued when a command is accepted and popped when rsp_valid appears.
module tb_iomem_initiator;
    import iomem_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;

    iomem_cmd_if cmd_if ();
    iomem_bus_if bus_if ();

    iomem_initiator #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .cmd  (cmd_if),
        .bus  (bus_if),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers a command until accepted; queues the expected response on acceptance.
    task automatic issue(input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                         input logic [31:0] exp_rd, input logic exp_err, output bit ok);
        rsp_t e;
        ok = 1'b0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_addr  = a;
        cmd_if.cmd_wdata = w;
        cmd_if.cmd_wstrb = s;
        for (int i = 0; i < 20; i++) begin
            if (cmd_if.cmd_ready) begin
                e.rdata = exp_rd;
                e.err   = exp_err;
                sb.push_back(e);
                step();
                ok = 1'b1;
                break;
            end
            step();
        end
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Responder: raises ready in valid cycle wait_n+1 (never if wait_n<0); returns in the cycle after valid falls.
    task automatic respond(input int wait_n, input logic [31:0] rd, output int vcyc, output bit stable);
        logic [31:0] a0, w0;
        logic [3:0]  s0;
        vcyc = 0;
        stable = 1'b1;
        a0 = '0; w0 = '0; s0 = '0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.iomem_valid) begin
                vcyc++;
                if (vcyc == 1) begin
                    a0 = bus_if.iomem_addr;
                    w0 = bus_if.iomem_wdata;
                    s0 = bus_if.iomem_wstrb;
                end else if (bus_if.iomem_addr !== a0 || bus_if.iomem_wdata !== w0 || bus_if.iomem_wstrb !== s0) begin
                    stable = 1'b0;
                end
                if (wait_n >= 0 && vcyc == wait_n + 1) begin
                    bus_if.iomem_ready = 1'b1;
                    bus_if.iomem_rdata = rd;
                end
            end else if (vcyc > 0 || i > 0) begin
                break;
            end
            step();
            bus_if.iomem_ready = 1'b0;
            bus_if.iomem_rdata = 32'hDEAD_BEEF;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (bus_if.iomem_valid !== 1'b0) begin bad++; $display("FAIL reset_iomem_valid got=%b exp=0", bus_if.iomem_valid); end
        total++; if (cmd_if.rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", cmd_if.rsp_valid); end
        total++; if (cmd_if.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", cmd_if.rsp_err); end
        total++; if (cmd_if.rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", cmd_if.rsp_rdata); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (bus_if.iomem_addr !== 32'h0 || bus_if.iomem_wdata !== 32'h0 || bus_if.iomem_wstrb !== 4'h0) begin
            bad++; $display("FAIL reset_bus_fields got=%h/%h/%h exp=0/0/0", bus_if.iomem_addr, bus_if.iomem_wdata, bus_if.iomem_wstrb);
        end
        rst = 1'b0;
        #1;
        total++; if (cmd_if.cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_if.cmd_ready); end
    endtask

    task automatic test_write();
        bit ok, st;
        int vc;
        rsp_t e;
        issue(32'h0300_0000, 32'h0000_00A5, 4'b0001, 32'h0, 1'b0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL write_accept got=%b exp=1", ok); end
        total++; if (bus_if.iomem_addr !== 32'h0300_0000 || bus_if.iomem_wdata !== 32'hA5 || bus_if.iomem_wstrb !== 4'b0001) begin
            bad++; $display("FAIL write_bus_fields got=%h/%h/%b exp=03000000/000000a5/0001", bus_if.iomem_addr, bus_if.iomem_wdata, bus_if.iomem_wstrb);
        end
        respond(2, 32'hCAFE_F00D, vc, st);
        total++; if (vc !== 3) begin bad++; $display("FAIL write_valid_cycles got=%0d exp=3", vc); end
        total++; if (st !== 1'b1) begin bad++; $display("FAIL write_bus_stable got=%b exp=1", st); end
        total++; if (cmd_if.rsp_valid !== 1'b1) begin bad++; $display("FAIL write_rsp_valid got=%b exp=1", cmd_if.rsp_valid); end
        e = sb.pop_front();
        total++; if (cmd_if.rsp_rdata !== e.rdata) begin bad++; $display("FAIL write_rsp_rdata got=%h exp=%h", cmd_if.rsp_rdata, e.rdata); end
        total++; if (cmd_if.rsp_err !== e.err) begin bad++; $display("FAIL write_rsp_err got=%b exp=%b", cmd_if.rsp_err, e.err); end
        cmd_if.rsp_ready = 1'b1;
        step();
        cmd_if.rsp_ready = 1'b0;
        total++; if (cmd_if.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL write_return_idle got=rsp_valid:%b busy:%b exp=0/0", cmd_if.rsp_valid, busy);
        end
    endtask

    task automatic test_read();
        bit ok, st;
        int vc;
        rsp_t e;
        issue(32'h0300_0004, 32'h0, 4'b0000, 32'h1234_5678, 1'b0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL read_accept got=%b exp=1", ok); end
        respond(0, 32'h1234_5678, vc, st);
        total++; if (vc !== 1) begin bad++; $display("FAIL read_valid_cycles got=%0d exp=1", vc); end
        total++; if (cmd_if.rsp_valid !== 1'b1) begin bad++; $display("FAIL read_rsp_valid got=%b exp=1", cmd_if.rsp_valid); end
        e = sb.pop_front();
        total++; if (cmd_if.rsp_rdata !== e.rdata) begin bad++; $display("FAIL read_rsp_rdata got=%h exp=%h", cmd_if.rsp_rdata, e.rdata); end
        total++; if (cmd_if.rsp_err !== e.err) begin bad++; $display("FAIL read_rsp_err got=%b exp=%b", cmd_if.rsp_err, e.err); end
        cmd_if.rsp_ready = 1'b1;
        step();
        cmd_if.rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok, st;
        int vc;
        rsp_t e;
        issue(32'h0300_0008, 32'h0, 4'b0000, 32'h0, 1'b1, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL tmo_accept got=%b exp=1", ok); end
        respond(-1, 32'h0, vc, st);
        total++; if (vc !== 8) begin bad++; $display("FAIL tmo_valid_cycles got=%0d exp=8", vc); end
        total++; if (cmd_if.rsp_valid !== 1'b1) begin bad++; $display("FAIL tmo_rsp_valid got=%b exp=1", cmd_if.rsp_valid); end
        e = sb.pop_front();
        total++; if (cmd_if.rsp_err !== e.err) begin bad++; $display("FAIL tmo_rsp_err got=%b exp=%b", cmd_if.rsp_err, e.err); end
        total++; if (cmd_if.rsp_rdata !== e.rdata) begin bad++; $display("FAIL tmo_rsp_rdata got=%h exp=%h", cmd_if.rsp_rdata, e.rdata); end
        bus_if.iomem_ready = 1'b1;
        bus_if.iomem_rdata = 32'h5555_AAAA;
        step();
        bus_if.iomem_ready = 1'b0;
        total++; if (cmd_if.rsp_valid !== 1'b1 || cmd_if.rsp_err !== 1'b1 || cmd_if.rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL tmo_late_ready got=%b/%b/%h exp=1/1/00000000", cmd_if.rsp_valid, cmd_if.rsp_err, cmd_if.rsp_rdata);
        end
        cmd_if.rsp_ready = 1'b1;
        step();
        cmd_if.rsp_ready = 1'b0;
        bus_if.iomem_ready = 1'b1;
        step();
        bus_if.iomem_ready = 1'b0;
        total++; if (busy !== 1'b0 || cmd_if.rsp_valid !== 1'b0 || bus_if.iomem_valid !== 1'b0) begin
            bad++; $display("FAIL idle_spurious_ready got=%b/%b/%b exp=0/0/0", busy, cmd_if.rsp_valid, bus_if.iomem_valid);
        end
    endtask

    task automatic test_ready_at_timeout();
        bit ok, st;
        int vc;
        rsp_t e;
        issue(32'h0300_000C, 32'h0, 4'b0000, 32'hA1B2_C3D4, 1'b0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL edge_accept got=%b exp=1", ok); end
        respond(7, 32'hA1B2_C3D4, vc, st);
        total++; if (vc !== 8) begin bad++; $display("FAIL edge_valid_cycles got=%0d exp=8", vc); end
        e = sb.pop_front();
        total++; if (cmd_if.rsp_err !== e.err) begin bad++; $display("FAIL edge_rsp_err got=%b exp=%b", cmd_if.rsp_err, e.err); end
        total++; if (cmd_if.rsp_rdata !== e.rdata) begin bad++; $display("FAIL edge_rsp_rdata got=%h exp=%h", cmd_if.rsp_rdata, e.rdata); end
        cmd_if.rsp_ready = 1'b1;
        step();
        cmd_if.rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok, st;
        int vc;
        rsp_t e;
        issue(32'h0300_0010, 32'h0, 4'b0000, 32'h0BAD_F00D, 1'b0, ok);
        total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_accept got=%b exp=1", ok); end
        respond(1, 32'h0BAD_F00D, vc, st);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_addr  = 32'h0300_0014;
        cmd_if.cmd_wdata = 32'h0000_0077;
        cmd_if.cmd_wstrb = 4'b1111;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            total++; if (cmd_if.rsp_valid !== 1'b1 || cmd_if.rsp_rdata !== e.rdata || cmd_if.rsp_err !== e.err) begin
                bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/%h/%b", i, cmd_if.rsp_valid, cmd_if.rsp_rdata, cmd_if.rsp_err, e.rdata, e.err);
            end
            total++; if (cmd_if.cmd_ready !== 1'b0 || bus_if.iomem_valid !== 1'b0) begin
                bad++; $display("FAIL bp_blocked cyc=%0d got=cmd_ready:%b iomem_valid:%b exp=0/0", i, cmd_if.cmd_ready, bus_if.iomem_valid);
            end
            step();
        end
        cmd_if.rsp_ready = 1'b1;
        step();
        cmd_if.rsp_ready = 1'b0;
        total++; if (cmd_if.rsp_valid !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got=%b/%b exp=0/1", cmd_if.rsp_valid, cmd_if.cmd_ready);
        end
        e.rdata = 32'h0;
        e.err   = 1'b0;
        sb.push_back(e);
        step();
        cmd_if.cmd_valid = 1'b0;
        total++; if (bus_if.iomem_valid !== 1'b1 || bus_if.iomem_addr !== 32'h0300_0014 || bus_if.iomem_wstrb !== 4'b1111) begin
            bad++; $display("FAIL bp_second_bus got=%b/%h/%b exp=1/03000014/1111", bus_if.iomem_valid, bus_if.iomem_addr, bus_if.iomem_wstrb);
        end
        respond(0, 32'h1234_0000, vc, st);
        e = sb.pop_front();
        total++; if (cmd_if.rsp_valid !== 1'b1 || cmd_if.rsp_rdata !== e.rdata || cmd_if.rsp_err !== e.err) begin
            bad++; $display("FAIL bp_second_rsp got=%b/%h/%b exp=1/%h/%b", cmd_if.rsp_valid, cmd_if.rsp_rdata, cmd_if.rsp_err, e.rdata, e.err);
        end
        cmd_if.rsp_ready = 1'b1;
        step();
        cmd_if.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_transfer();
        bit ok, st;
        int vc;
        rsp_t e;
        issue(32'h0300_0018, 32'h0, 4'b0000, 32'h0, 1'b0, ok);
        void'(sb.pop_back());
        total++; if (bus_if.iomem_valid !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rstmid_in_bus got=%b/%b exp=1/1", bus_if.iomem_valid, busy);
        end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus_if.iomem_valid !== 1'b0 || busy !== 1'b0 || cmd_if.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL rstmid_immediate got=%b/%b/%b exp=0/0/0", bus_if.iomem_valid, busy, cmd_if.rsp_valid);
        end
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (cmd_if.rsp_valid !== 1'b0 || bus_if.iomem_valid !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
                bad++; $display("FAIL rstmid_quiet cyc=%0d got=%b/%b/%b exp=0/0/1", i, cmd_if.rsp_valid, bus_if.iomem_valid, cmd_if.cmd_ready);
            end
        end
        issue(32'h0300_001C, 32'h0000_BEEF, 4'b0011, 32'h0, 1'b0, ok);
        respond(1, 32'h7777_7777, vc, st);
        e = sb.pop_front();
        total++; if (vc !== 2 || cmd_if.rsp_valid !== 1'b1 || cmd_if.rsp_rdata !== e.rdata || cmd_if.rsp_err !== e.err) begin
            bad++; $display("FAIL rstmid_next got=%0d/%b/%h/%b exp=2/1/%h/%b", vc, cmd_if.rsp_valid, cmd_if.rsp_rdata, cmd_if.rsp_err, e.rdata, e.err);
        end
        cmd_if.rsp_ready = 1'b1;
        step();
        cmd_if.rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        rsp_t e;
        int idx, last_acc;
        logic prev_valid;
        addrs[0] = 32'h0300_0020;
        addrs[1] = 32'h0300_0024;
        addrs[2] = 32'h0300_0028;
        idx = 0;
        last_acc = -1;
        prev_valid = 1'b0;
        cmd_if.rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            total++; if (bus_if.iomem_valid === 1'b1 && prev_valid === 1'b1) begin
                bad++; $display("FAIL b2b_valid_gap cyc=%0d got=11 exp=no consecutive", c);
            end
            if (cmd_if.rsp_valid === 1'b1) begin
                e = sb.pop_front();
                total++; if (cmd_if.rsp_rdata !== e.rdata || cmd_if.rsp_err !== e.err) begin
                    bad++; $display("FAIL b2b_rsp cyc=%0d got=%h/%b exp=%h/%b", c, cmd_if.rsp_rdata, cmd_if.rsp_err, e.rdata, e.err);
                end
            end
            if (idx < 3) begin
                cmd_if.cmd_valid = 1'b1;
                cmd_if.cmd_addr  = addrs[idx];
                cmd_if.cmd_wdata = 32'h0;
                cmd_if.cmd_wstrb = 4'b0000;
                if (cmd_if.cmd_ready === 1'b1) begin
                    if (last_acc >= 0) begin
                        total++; if (c - last_acc !== 3) begin
                            bad++; $display("FAIL b2b_spacing got=%0d exp=3", c - last_acc);
                        end
                    end
                    last_acc = c;
                    e.rdata = addrs[idx] ^ 32'hFFFF_0000;
                    e.err   = 1'b0;
                    sb.push_back(e);
                    idx++;
                end
            end else begin
                cmd_if.cmd_valid = 1'b0;
            end
            bus_if.iomem_ready = bus_if.iomem_valid;
            bus_if.iomem_rdata = bus_if.iomem_addr ^ 32'hFFFF_0000;
            prev_valid = bus_if.iomem_valid;
            step();
        end
        cmd_if.cmd_valid = 1'b0;
        cmd_if.rsp_ready = 1'b0;
        bus_if.iomem_ready = 1'b0;
        total++; if (idx !== 3) begin bad++; $display("FAIL b2b_accepted got=%0d exp=3", idx); end
    endtask

    initial begin
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_addr  = '0;
        cmd_if.cmd_wdata = '0;
        cmd_if.cmd_wstrb = '0;
        cmd_if.rsp_ready = 1'b0;
        bus_if.iomem_ready = 1'b0;
        bus_if.iomem_rdata = 32'hDEAD_BEEF;

        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ready_at_timeout();
        test_backpressure();
        test_reset_mid_transfer();
        test_back_to_back();

        total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iomem_initiator.md
IOMEM_INITIATOR -- requirements
Module: iomem_initiator

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles iomem_valid stays high without iomem_ready before the transfer is abandoned (legal range 1..65535).
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: cmd_valid  input  1  command offered.
REQ-006 Port: cmd_ready  output  1  command accepted when high together with cmd_valid.
REQ-007 Port: cmd_addr  input  32  target byte address.
REQ-008 Port: cmd_wdata  input  32  write data.
REQ-009 Port: cmd_wstrb  input  4  byte enables; 4'b0000 means read.
REQ-010 Port: iomem_valid  output  1  bus request.
REQ-011 Port: iomem_ready  input  1  responder completion pulse.
REQ-012 Port: iomem_addr / iomem_wdata  output  32 each  bus address / write data.
REQ-013 Port: iomem_wstrb  output  4  bus byte enables.
REQ-014 Port: iomem_rdata  input  32  read data, valid only in the iomem_ready cycle.
REQ-015 Port: rsp_valid  output  1  response available.
REQ-016 Port: rsp_ready  input  1  response consumed when high together with rsp_valid.
REQ-017 Port: rsp_rdata  output  32  captured read data (0 for writes and timeouts).
REQ-018 Port: rsp_err  output  1  1 = transfer abandoned on timeout.
REQ-019 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-020 FSM states SHALL be IDLE, BUS and RESP.
REQ-021 cmd_ready SHALL be high only in IDLE; cmd_valid&cmd_ready SHALL register addr/wdata/wstrb and move the FSM to BUS.
REQ-022 Latency: a command accepted in cycle N SHALL produce iomem_valid high in cycle N+1.
REQ-023 In BUS, iomem_valid SHALL stay high with iomem_addr, iomem_wdata and iomem_wstrb stable until iomem_ready is sampled high or the timeout fires.
REQ-024 When iomem_ready is sampled high in cycle M, the block SHALL capture iomem_rdata and drop iomem_valid in cycle M+1, with rsp_valid=1 and rsp_err=0 in cycle M+1; the state SHALL move to RESP.
REQ-025 For writes (wstrb!=0), rsp_rdata SHALL be 0.
REQ-026 Timeout counter SHALL clear on BUS entry and increment each BUS cycle without ready; when it reaches TIMEOUT_CYCLES, the block SHALL drop iomem_valid and enter RESP with rsp_err=1 and rsp_rdata=0.
REQ-027 If iomem_ready is high in the same cycle the timeout would fire, success SHALL take priority (rsp_err=0).
REQ-028 iomem_ready sampled in IDLE or RESP SHALL be ignored (late or spurious pulses).
REQ-029 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready; the handshake SHALL return to IDLE with rsp_valid low in the next cycle.
REQ-030 At most one transfer SHALL be outstanding; minimum command-to-command spacing is 3 cycles with a zero-wait responder.
REQ-031 iomem_valid SHALL never be high in two consecutive transfers without an intervening low cycle.

Reset
REQ-032 Asserting rst SHALL immediately force state=IDLE and counter=0, and drive iomem_valid=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, and iomem_addr/wdata/wstrb=0; cmd_ready=1 after release.
REQ-033 Reset mid-transfer SHALL abandon it with no response generated.

Structure
REQ-034 A shared package iomem_pkg SHALL hold the FSM state enum, IOMEM_AW=32, IOMEM_DW=32 and IOMEM_SW=4.
REQ-035 The timeout counter SHALL be a sub-module, iomem_timeout_ctr (inputs clear/enable, output expired).

Verification
REQ-036 Write addr 0x03000000, wdata 0x000000A5, wstrb 0001; responder asserts ready 2 cycles after valid -> valid high exactly 3 cycles, addr/wdata stable throughout, rsp_valid with err=0, rdata=0.
REQ-037 Read addr 0x03000004, responder returns 0x12345678 with zero wait -> rsp_rdata=0x12345678 one cycle after ready, err=0.
REQ-038 TIMEOUT_CYCLES=8, responder silent -> valid dropped after 8 cycles, rsp_err=1, rsp_rdata=0; a later ready pulse is ignored.
REQ-039 Ready arrives in the same cycle the timeout expires -> err=0 and data captured.
REQ-040 rsp_ready held low 5 cycles -> rsp fields stable, cmd_ready low, second command queued at input accepted only after the handshake.
REQ-041 rst asserted in BUS -> iomem_valid and busy low within the same cycle, no rsp_valid, next command proceeds normally.
